// File: rtl/maxpool_layer3.sv
// rtl/maxpool_layer3.sv - 2x2 stride-2 signed max pooling over a raster pixel stream
//
// Purpose: streams an IMG_W x IMG_H feature map of CH channels (one pixel per
// in_valid beat, row-major) and emits the (IMG_W/2) x (IMG_H/2) pooled map in
// raster order, one out_valid pulse per pooled pixel, 1 clock after the
// window's 4th pixel.
//
// Ports:
//   clk                      rising-edge clock
//   rst_n                    asynchronous active-low reset
//   in_valid                 in_data* carry one pixel this cycle
//   in_data0..in_data31      signed 8-bit pixel per channel
//   out_valid                one-cycle pulse marking a pooled pixel
//   out_data0..out_data31    signed 8-bit pooled value per channel (held)

module maxpool_layer3 #(
   parameter int IMG_W = 14,
   parameter int IMG_H = 14,
   parameter int CH    = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data0,
   input  logic [7:0] in_data1,
   input  logic [7:0] in_data2,
   input  logic [7:0] in_data3,
   input  logic [7:0] in_data4,
   input  logic [7:0] in_data5,
   input  logic [7:0] in_data6,
   input  logic [7:0] in_data7,
   input  logic [7:0] in_data8,
   input  logic [7:0] in_data9,
   input  logic [7:0] in_data10,
   input  logic [7:0] in_data11,
   input  logic [7:0] in_data12,
   input  logic [7:0] in_data13,
   input  logic [7:0] in_data14,
   input  logic [7:0] in_data15,
   input  logic [7:0] in_data16,
   input  logic [7:0] in_data17,
   input  logic [7:0] in_data18,
   input  logic [7:0] in_data19,
   input  logic [7:0] in_data20,
   input  logic [7:0] in_data21,
   input  logic [7:0] in_data22,
   input  logic [7:0] in_data23,
   input  logic [7:0] in_data24,
   input  logic [7:0] in_data25,
   input  logic [7:0] in_data26,
   input  logic [7:0] in_data27,
   input  logic [7:0] in_data28,
   input  logic [7:0] in_data29,
   input  logic [7:0] in_data30,
   input  logic [7:0] in_data31,
   output logic       out_valid,
   output logic [7:0] out_data0,
   output logic [7:0] out_data1,
   output logic [7:0] out_data2,
   output logic [7:0] out_data3,
   output logic [7:0] out_data4,
   output logic [7:0] out_data5,
   output logic [7:0] out_data6,
   output logic [7:0] out_data7,
   output logic [7:0] out_data8,
   output logic [7:0] out_data9,
   output logic [7:0] out_data10,
   output logic [7:0] out_data11,
   output logic [7:0] out_data12,
   output logic [7:0] out_data13,
   output logic [7:0] out_data14,
   output logic [7:0] out_data15,
   output logic [7:0] out_data16,
   output logic [7:0] out_data17,
   output logic [7:0] out_data18,
   output logic [7:0] out_data19,
   output logic [7:0] out_data20,
   output logic [7:0] out_data21,
   output logic [7:0] out_data22,
   output logic [7:0] out_data23,
   output logic [7:0] out_data24,
   output logic [7:0] out_data25,
   output logic [7:0] out_data26,
   output logic [7:0] out_data27,
   output logic [7:0] out_data28,
   output logic [7:0] out_data29,
   output logic [7:0] out_data30,
   output logic [7:0] out_data31
);

   localparam int NLANE    = 32;
   localparam int CW       = $clog2(IMG_W);
   localparam int RW       = $clog2(IMG_H);
   localparam int HALF_W   = IMG_W / 2;
   localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

   logic [CW-1:0]          col;
   logic [RW-1:0]          row;
   logic [NLANE*8-1:0]     in_bus;
   logic [NLANE*8-1:0]     out_bus;

   // odd column closes a horizontal pair; odd row closes the 2x2 window
   logic pair_done;
   logic win_done;

   assign pair_done = in_valid & col[0];
   assign win_done  = pair_done & row[0];

   assign in_bus = {in_data31, in_data30, in_data29, in_data28,
                    in_data27, in_data26, in_data25, in_data24,
                    in_data23, in_data22, in_data21, in_data20,
                    in_data19, in_data18, in_data17, in_data16,
                    in_data15, in_data14, in_data13, in_data12,
                    in_data11, in_data10, in_data9,  in_data8,
                    in_data7,  in_data6,  in_data5,  in_data4,
                    in_data3,  in_data2,  in_data1,  in_data0};

   // raster position; only valid beats move it, so bubbles are transparent
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= win_done;
         if (in_valid) begin
            if (col == LAST_COL) begin
               col <= '0;
               row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   for (genvar c = 0; c < NLANE; c++) begin : g_lane
      if (c < CH) begin : g_act
         logic signed [7:0] px;
         logic signed [7:0] hold;
         logic signed [7:0] hmax;
         logic signed [7:0] lbv;
         logic signed [7:0] vmax;
         logic signed [7:0] out_q;
         logic signed [7:0] lb [HALF_W];

         assign px   = in_bus[c*8 +: 8];
         assign hmax = (px > hold) ? px : hold;
         // entry col>>1 was written on the previous (even) row and is read
         // here before the next even row can overwrite it
         assign lbv  = lb[col[CW-1:1]];
         assign vmax = (lbv > hmax) ? lbv : hmax;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               hold  <= '0;
               out_q <= '0;
            end else if (in_valid) begin
               if (!col[0]) begin
                  hold <= px;
               end else if (row[0]) begin
                  out_q <= vmax;
               end
            end
         end

         // line buffer carries no reset: every entry is rewritten on an even
         // row before the odd row that reads it
         always_ff @(posedge clk) begin
            if (pair_done && !row[0]) begin
               lb[col[CW-1:1]] <= hmax;
            end
         end

         assign out_bus[c*8 +: 8] = out_q;
      end else begin : g_off
         assign out_bus[c*8 +: 8] = 8'h00;
      end
   end

   assign out_data0  = out_bus[0*8   +: 8];
   assign out_data1  = out_bus[1*8   +: 8];
   assign out_data2  = out_bus[2*8   +: 8];
   assign out_data3  = out_bus[3*8   +: 8];
   assign out_data4  = out_bus[4*8   +: 8];
   assign out_data5  = out_bus[5*8   +: 8];
   assign out_data6  = out_bus[6*8   +: 8];
   assign out_data7  = out_bus[7*8   +: 8];
   assign out_data8  = out_bus[8*8   +: 8];
   assign out_data9  = out_bus[9*8   +: 8];
   assign out_data10 = out_bus[10*8  +: 8];
   assign out_data11 = out_bus[11*8  +: 8];
   assign out_data12 = out_bus[12*8  +: 8];
   assign out_data13 = out_bus[13*8  +: 8];
   assign out_data14 = out_bus[14*8  +: 8];
   assign out_data15 = out_bus[15*8  +: 8];
   assign out_data16 = out_bus[16*8  +: 8];
   assign out_data17 = out_bus[17*8  +: 8];
   assign out_data18 = out_bus[18*8  +: 8];
   assign out_data19 = out_bus[19*8  +: 8];
   assign out_data20 = out_bus[20*8  +: 8];
   assign out_data21 = out_bus[21*8  +: 8];
   assign out_data22 = out_bus[22*8  +: 8];
   assign out_data23 = out_bus[23*8  +: 8];
   assign out_data24 = out_bus[24*8  +: 8];
   assign out_data25 = out_bus[25*8  +: 8];
   assign out_data26 = out_bus[26*8  +: 8];
   assign out_data27 = out_bus[27*8  +: 8];
   assign out_data28 = out_bus[28*8  +: 8];
   assign out_data29 = out_bus[29*8  +: 8];
   assign out_data30 = out_bus[30*8  +: 8];
   assign out_data31 = out_bus[31*8  +: 8];

endmodule
